cpu_commit_stage: RTL and testbench

CPU_COMMIT_STAGE -- requirements
Module: cpu_commit_stage

---
 rtl/cpu_commit_stage.sv | 200 ++++++++++++++++++++
 tb/tb_cpu_commit_stage.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_commit_stage.sv
// cpu_commit_stage
//   Commit / memory / writeback stage. Accepts one op per handshake from the
//   commit bus. Non-memory ops write back on the next cycle. Loads and stores
//   issue a data-memory request and hold it until dmem_ack arrives. A branch
//   redirect is signalled combinationally when the op is accepted.
//
//   Build option: define COMMIT_TIMEOUT_EN to add a memory-wait watchdog.
//   After TIMEOUT_CYCLES wait cycles with no ack, the stage abandons the
//   access. It sends a writeback pulse with wb_reg_write=0 and sets the sticky
//   mem_error flag. Without the macro the stage waits forever and mem_error
//   is tied low.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   commit-bus handshake
//   in_*                control fields, ALU result/address, store data,
//                       branch target, destination register
//   branch_taken/target redirect to fetch (combinational)
//   dmem_*              data-memory request/response
//   wb_*                writeback register outputs
//   mem_error           sticky watchdog flag
//
// state    | meaning
// IDLE     | ready for a new op; non-memory ops complete here
// WAIT_ACK | memory request outstanding, holding dmem_* until ack

`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif
`ifndef NUM_REGS
`define NUM_REGS 32
`endif

module cpu_commit_stage #(
    parameter int REG_WIDTH      = `REG_WIDTH,
    parameter int NUM_REGS       = `NUM_REGS,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int RD_W          = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_branch,
    input  logic                 in_mem_write,
    input  logic                 in_mem_read,
    input  logic                 in_mem_to_reg,
    input  logic                 in_reg_write,
    input  logic                 in_zero,
    input  logic [REG_WIDTH-1:0] in_alu_result,
    input  logic [REG_WIDTH-1:0] in_rb_data,
    input  logic [REG_WIDTH-1:0] in_branch_result,
    input  logic [RD_W-1:0]      in_reg_dest,
    output logic                 branch_taken,
    output logic [REG_WIDTH-1:0] branch_target,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [REG_WIDTH-1:0] dmem_addr,
    output logic [REG_WIDTH-1:0] dmem_wdata,
    input  logic [REG_WIDTH-1:0] dmem_rdata,
    input  logic                 dmem_ack,
    output logic                 wb_valid,
    output logic                 wb_reg_write,
    output logic [RD_W-1:0]      wb_reg_dest,
    output logic [REG_WIDTH-1:0] wb_data,
    output logic                 mem_error
);

    if (TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic accept;
    logic is_mem;
    logic mem_done;
    logic timeout;

    // Fields of the outstanding memory op needed at writeback
    logic                 p_reg_write;
    logic                 p_mem_to_reg;
    logic [RD_W-1:0]      p_reg_dest;

    assign in_ready      = (state == IDLE);
    assign accept        = in_valid & in_ready;
    assign is_mem        = in_mem_read | in_mem_write;
    assign branch_taken  = accept & in_branch & in_zero;
    assign branch_target = in_branch_result;
    assign mem_done      = (state == WAIT_ACK) & dmem_ack;

`ifdef COMMIT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] to_cnt;

    // The down-counter reaches zero during the last permitted wait cycle.
    // An ack in that same cycle still completes normally.
    assign timeout = (state == WAIT_ACK) & ~dmem_ack & (to_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt    <= '0;
            mem_error <= 1'b0;
        end else begin
            if (accept && is_mem) begin
                to_cnt <= CNT_W'(TIMEOUT_CYCLES - 1);
            end else if (state == WAIT_ACK && to_cnt != '0) begin
                to_cnt <= to_cnt - 1'b1;
            end
            if (timeout) begin
                mem_error <= 1'b1;
            end
        end
    end
`else
    assign timeout   = 1'b0;
    assign mem_error = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && is_mem) begin
                    state_nxt = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (dmem_ack || timeout) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_reg_dest  <= '0;
            wb_data      <= '0;
            p_reg_write  <= 1'b0;
            p_mem_to_reg <= 1'b0;
            p_reg_dest   <= '0;
        end else begin
            wb_valid <= 1'b0;
            if (accept) begin
                if (is_mem) begin
                    // A write flag wins when both mem flags are set
                    dmem_req     <= 1'b1;
                    dmem_we      <= in_mem_write;
                    dmem_addr    <= in_alu_result;
                    dmem_wdata   <= in_rb_data;
                    p_reg_write  <= in_reg_write;
                    p_mem_to_reg <= in_mem_to_reg;
                    p_reg_dest   <= in_reg_dest;
                end else begin
                    wb_valid     <= 1'b1;
                    wb_reg_write <= in_reg_write;
                    wb_reg_dest  <= in_reg_dest;
                    wb_data      <= in_alu_result;
                end
            end else if (mem_done) begin
                dmem_req     <= 1'b0;
                dmem_we      <= 1'b0;
                wb_valid     <= 1'b1;
                wb_reg_write <= p_reg_write;
                wb_reg_dest  <= p_reg_dest;
                wb_data      <= p_mem_to_reg ? dmem_rdata : dmem_addr;
            end else if (timeout) begin
                dmem_req     <= 1'b0;
                dmem_we      <= 1'b0;
                wb_valid     <= 1'b1;
                wb_reg_write <= 1'b0;
                wb_reg_dest  <= p_reg_dest;
                wb_data      <= dmem_addr;
            end
        end
    end

endmodule

// File: tb/tb_cpu_commit_stage.sv
module tb_cpu_commit_stage;

    localparam int W   = 32;
    localparam int NR  = 32;
    localparam int RDW = 5;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid, in_ready;
    logic           in_branch, in_mem_write, in_mem_read, in_mem_to_reg, in_reg_write, in_zero;
    logic [W-1:0]   in_alu_result, in_rb_data, in_branch_result;
    logic [RDW-1:0] in_reg_dest;
    logic           branch_taken;
    logic [W-1:0]   branch_target;
    logic           dmem_req, dmem_we;
    logic [W-1:0]   dmem_addr, dmem_wdata, dmem_rdata;
    logic           dmem_ack;
    logic           wb_valid, wb_reg_write;
    logic [RDW-1:0] wb_reg_dest;
    logic [W-1:0]   wb_data;
    logic           mem_error;

    cpu_commit_stage #(
        .REG_WIDTH     (W),
        .NUM_REGS      (NR),
        .TIMEOUT_CYCLES(255)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_branch       (in_branch),
        .in_mem_write    (in_mem_write),
        .in_mem_read     (in_mem_read),
        .in_mem_to_reg   (in_mem_to_reg),
        .in_reg_write    (in_reg_write),
        .in_zero         (in_zero),
        .in_alu_result   (in_alu_result),
        .in_rb_data      (in_rb_data),
        .in_branch_result(in_branch_result),
        .in_reg_dest     (in_reg_dest),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .dmem_rdata      (dmem_rdata),
        .dmem_ack        (dmem_ack),
        .wb_valid        (wb_valid),
        .wb_reg_write    (wb_reg_write),
        .wb_reg_dest     (wb_reg_dest),
        .wb_data         (wb_data),
        .mem_error       (mem_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level reference: one outstanding memory op at most,
    // plus the last writeback record.
    bit             m_busy;
    bit             m_wbv, m_wbrw;
    logic [RDW-1:0] m_dest;
    logic [W-1:0]   m_data;
    bit             p_we, p_m2r, p_rw;
    logic [RDW-1:0] p_dest;
    logic [W-1:0]   p_addr, p_wd;
    int             req_cnt;

    task automatic model_reset();
        m_busy = 0; m_wbv = 0; m_wbrw = 0; m_dest = '0; m_data = '0;
    endtask

    task automatic set_op(input bit v, input bit br, input bit mw, input bit mr, input bit m2r,
                          input bit rw, input bit z, input logic [W-1:0] alu,
                          input logic [W-1:0] rb, input logic [W-1:0] bres,
                          input logic [RDW-1:0] dest);
        in_valid = v; in_branch = br; in_mem_write = mw; in_mem_read = mr;
        in_mem_to_reg = m2r; in_reg_write = rw; in_zero = z;
        in_alu_result = alu; in_rb_data = rb; in_branch_result = bres; in_reg_dest = dest;
    endtask

    task automatic idle_op();
        set_op(0, 0, 0, 0, 0, 0, 0, '0, '0, '0, '0);
    endtask

    task automatic check_now();
        check("in_ready", in_ready, !m_busy);
        check("dmem_req", dmem_req, m_busy);
        if (m_busy) begin
            req_cnt++;
            check("dmem_we", dmem_we, p_we);
            check("dmem_addr", dmem_addr, p_addr);
            check("dmem_wdata", dmem_wdata, p_wd);
        end
        check("wb_valid", wb_valid, m_wbv);
        check("wb_reg_write", wb_reg_write, m_wbrw);
        check("wb_reg_dest", wb_reg_dest, m_dest);
        check("wb_data", wb_data, m_data);
        check("branch_taken", branch_taken, in_valid & !m_busy & in_branch & in_zero);
        check("branch_target", branch_target, in_branch_result);
        check("mem_error", mem_error, 1'b0);
    endtask

    task automatic model_edge();
        if (m_busy) begin
            if (dmem_ack) begin
                m_busy = 0;
                m_wbv  = 1;
                m_wbrw = p_rw;
                m_dest = p_dest;
                m_data = p_m2r ? dmem_rdata : p_addr;
            end else begin
                m_wbv = 0;
            end
        end else if (in_valid) begin
            if (in_mem_read || in_mem_write) begin
                m_busy = 1; m_wbv = 0;
                p_we = in_mem_write; p_m2r = in_mem_to_reg; p_rw = in_reg_write;
                p_dest = in_reg_dest; p_addr = in_alu_result; p_wd = in_rb_data;
            end else begin
                m_wbv = 1; m_wbrw = in_reg_write; m_dest = in_reg_dest; m_data = in_alu_result;
            end
        end else begin
            m_wbv = 0;
        end
    endtask

    // One clock: check mid-cycle, advance model at the edge, then allow new drives.
    task automatic cyc();
        @(negedge clk);
        check_now();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_op();
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        req_cnt = 0;
        model_reset();
        #3;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_dmem_req", dmem_req, 1'b0);
        check("rst_wb_valid", wb_valid, 1'b0);
        check("rst_wb_data", wb_data, '0);
        check("rst_dmem_addr", dmem_addr, '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // ALU op accepted on the first edge after reset release
        set_op(1, 0, 0, 0, 0, 1, 0, 32'h1234, 32'h0, 32'h0, 5'd5);
        cyc();
        idle_op();
        check("alu_wb_valid", wb_valid, 1'b1);
        check("alu_wb_dest", wb_reg_dest, 5'd5);
        check("alu_wb_data", wb_data, 32'h1234);
        cyc();
        check("alu_wb_pulse", wb_valid, 1'b0);

        // Load with 3 wait cycles before ack
        set_op(1, 0, 0, 1, 1, 1, 0, 32'h40, 32'h0, 32'h0, 5'd7);
        req_cnt = 0;
        cyc();
        idle_op();
        repeat (3) begin
            check("load_in_ready", in_ready, 1'b0);
            cyc();
        end
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFE;
        cyc();
        dmem_ack = 1'b0; dmem_rdata = '0;
        check("load_req_cycles", req_cnt, 4);
        check("load_wb_data", wb_data, 32'hCAFE);
        check("load_wb_valid", wb_valid, 1'b1);
        cyc();

        // Store acked in the first request cycle
        set_op(1, 0, 1, 0, 0, 0, 0, 32'h80, 32'h55, 32'h0, 5'd3);
        cyc();
        idle_op();
        check("store_we", dmem_we, 1'b1);
        check("store_wdata", dmem_wdata, 32'h55);
        check("store_addr", dmem_addr, 32'h80);
        dmem_ack = 1'b1;
        cyc();
        dmem_ack = 1'b0;
        check("store_ready", in_ready, 1'b1);
        check("store_wb_rw", wb_reg_write, 1'b0);
        check("store_wb_valid", wb_valid, 1'b1);
        cyc();

        // Branch taken / not taken
        set_op(1, 1, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h100, 5'd0);
        #1;
        check("br_taken", branch_taken, 1'b1);
        check("br_target", branch_target, 32'h100);
        cyc();
        in_zero = 1'b0;
        #1;
        check("br_not_taken", branch_taken, 1'b0);
        cyc();

        // Branch combined with a store: redirect at accept, store still runs
        set_op(1, 1, 1, 1, 0, 0, 1, 32'h44, 32'h99, 32'h200, 5'd0);
        #1;
        check("brmem_taken", branch_taken, 1'b1);
        cyc();
        idle_op();
        check("brmem_we_both", dmem_we, 1'b1);
        cyc();
        dmem_ack = 1'b1;
        cyc();
        dmem_ack = 1'b0;

        // Back-to-back ALU ops
        for (int i = 0; i < 4; i++) begin
            set_op(1, 0, 0, 0, 0, 1, 0, 32'h1000 + i, 32'h0, 32'h0, 5'(i + 10));
            cyc();
        end
        idle_op();
        check("b2b_last", wb_data, 32'h1003);
        cyc();

        // Ack while idle is ignored
        dmem_ack = 1'b1; dmem_rdata = 32'hDEAD;
        repeat (3) cyc();
        dmem_ack = 1'b0;

        // Reset during WAIT_ACK discards the op
        set_op(1, 0, 0, 1, 1, 1, 0, 32'h60, 32'h0, 32'h0, 5'd9);
        cyc();
        idle_op();
        cyc();
        rst_n = 1'b0;
        #1;
        check("rstw_dmem_req", dmem_req, 1'b0);
        check("rstw_in_ready", in_ready, 1'b1);
        check("rstw_wb_data", wb_data, '0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        dmem_ack = 1'b1;
        repeat (3) begin
            cyc();
            check("rstw_no_wb", wb_valid, 1'b0);
        end
        dmem_ack = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            set_op(($urandom_range(0, 9) < 7), $urandom_range(0, 1), ($urandom_range(0, 9) < 3),
                   ($urandom_range(0, 9) < 3), $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 1), $urandom, $urandom, $urandom, 5'($urandom));
            dmem_ack   = ($urandom_range(0, 9) < 4);
            dmem_rdata = $urandom;
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
